spart_rx: RTL
=============

# spart_rx

Receive stage of the SPART: deserialises the asynchronous `rxd` line (8N1, LSB first) into a byte for the bus interface. Sits between the serial pin (driven by the terminal model in simulation) and the SPART bus/databus logic, which reads `rx_data` when `rda` is high. Uses a 16x oversampling tick from the SPART baud generator; the block contains no divisor logic of its own.

## Interface
- `OVERSAMPLE`, 16: enable ticks per bit period. Must be even and ≥ 4.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `enable` input 1: single-cycle oversample tick from the baud generator, pulsed OVERSAMPLE times per bit.
- `rxd` input 1: asynchronous serial input, idle high.
- `clr_rda` input 1: one-cycle pulse from the bus logic when it has read `rx_data`.
- `rx_data` output 8: last received byte.
- `rda` output 1: received data available.
- `frame_err` output 1: stop bit of the byte in `rx_data` sampled low.
- `overrun` output 1: a byte completed while `rda` was still set.

## Operation
- `rxd` passes through a 2-FF synchroniser that resets to 1. All sampling uses the synchronised value `rxs`.
- Tick counter `tcnt` is 4 bits for OVERSAMPLE=16 (width log2(OVERSAMPLE)). Bit counter `bcnt` is 3 bits. Shift register `sh` is 8 bits, shifting right with the new bit entering at bit 7.
- FSM states are IDLE, START, DATA, STOP. All counting advances only on cycles with `enable`=1.
- IDLE: on an `enable` tick with `rxs`=0, go to START with `tcnt`=0.
- START: when `tcnt` reaches OVERSAMPLE/2−1, sample `rxs`.
  - If 0, go to DATA with `tcnt`=0 and `bcnt`=0.
  - If 1, this is a glitch or false start: return to IDLE and change no outputs.
- DATA: when `tcnt` reaches OVERSAMPLE−1, shift `rxs` into `sh` and reset `tcnt`.
  - After the 8th bit (`bcnt`=7), go to STOP. Otherwise increment `bcnt`.
- STOP: when `tcnt` reaches OVERSAMPLE−1, complete the byte:
  - `rx_data` ← `sh`
  - `rda` ← 1
  - `frame_err` ← ~`rxs`
  - `overrun` ← `rda` (old value)
  - then go to IDLE.
- The byte is delivered even when `frame_err` is set.
- Overrun overwrites `rx_data` with the newer byte.
- `clr_rda` clears `rda`, `frame_err` and `overrun` on the next edge. `rx_data` is held until the next completion.
- If byte completion and `clr_rda` occur in the same cycle, completion wins: `rda`=1, `frame_err` is taken from the new stop bit, and `overrun`=0 because the old byte was consumed.
- A break (`rxd` held low) produces a byte of 0x00 with `frame_err`=1. The FSM then re-arms in IDLE and treats the continuing low as a new start edge.

## Timing
- Reset values: `rx_data`=0x00, `rda`=0, `frame_err`=0, `overrun`=0, FSM=IDLE, counters=0, synchroniser=1.
- Reset mid-frame aborts the frame immediately and discards the partial byte. Outputs take their reset values on that edge.
- Input latency is 2 clk from `rxd` to `rxs`.
- With `enable` tied high and OVERSAMPLE=16, a frame is 160 clk. The start bit is validated 8 clk after detection, and data bits are sampled at mid-bit every 16 clk.
- `rda` rises on the clk edge after the `enable` tick that samples the stop bit, which is mid-stop-bit. The receiver is back in IDLE by then, so a start edge is accepted half a bit later.
- `enable` pulses with no activity in IDLE do nothing. Ticks only advance the counters.
- `clr_rda` is honoured on any cycle regardless of `enable`.

## Test plan
- Send 0xA5 in 8N1 with `enable`=1 constant. Expect `rda`=1, `rx_data`=0xA5 and `frame_err`=0 exactly 2+152+1 clk after the start edge, ±1 clk. Pulse `clr_rda` and expect `rda`=0 on the next edge with `rx_data` still 0xA5.
- Send back-to-back bytes 0x00, 0xFF and 0x3C with no idle gap, pulsing `clr_rda` after each. Expect three captures with the correct values and `overrun`=0 throughout.
- Send 0x55 and 0x81 without clearing `rda`. Expect `rx_data`=0x81, `rda`=1 and `overrun`=1. Then pulse `clr_rda` on the exact completion cycle of a third byte 0x7E; expect `rda`=1, `overrun`=0 and `rx_data`=0x7E.
- Send a byte 0x96 with the stop bit forced low. Expect `rx_data`=0x96, `rda`=1 and `frame_err`=1. Then hold `rxd` low for 20 bit times and expect 0x00 bytes with `frame_err`=1.
- Apply a low glitch of 4 clk on an idle line. Expect the FSM back in IDLE, `rda` still 0, and a following 0xC3 received correctly.
- Assert `rst` for 1 clk midway through data bit 4 of 0xF0. Expect all outputs at reset values on that edge, and a clean reception of the next byte 0x12.

Source files
------------

// File: rtl/spart_rx.sv
// -----------------------------------------------------------------------------
// spart_rx : SPART receive stage.
//
// Deserialises an asynchronous 8N1 serial line (LSB first) into a byte for the
// SPART bus logic, using an external OVERSAMPLE x bit-rate enable tick.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        synchronous active-high reset
//   enable_i     single-cycle oversample tick (OVERSAMPLE per bit period)
//   rxd_i        asynchronous serial input, idle high
//   clr_rda_i    one-cycle pulse: bus logic has consumed rx_data_o
//   rx_data_o    last received byte
//   rda_o        received data available
//   frame_err_o  stop bit of the byte in rx_data_o was sampled low
//   overrun_o    a byte completed while rda_o was still set
// -----------------------------------------------------------------------------
module spart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic       rxd_i,
    input  logic       clr_rda_i,
    output logic [7:0] rx_data_o,
    output logic       rda_o,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int TW = $clog2(OVERSAMPLE);
    typedef logic [TW-1:0] tcnt_t;

    // Start bit is checked at its middle; data/stop bits one full period later.
    localparam tcnt_t HALF_M1 = tcnt_t'(OVERSAMPLE / 2 - 1);
    localparam tcnt_t FULL_M1 = tcnt_t'(OVERSAMPLE - 1);
    localparam tcnt_t TCNT_ONE = tcnt_t'(1'b1);
    localparam tcnt_t TCNT_ZERO = tcnt_t'(1'b0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [1:0] sync_q;
    logic       rxs_s;
    state_t     state_q, state_d;
    tcnt_t      tcnt_q, tcnt_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic [7:0] sh_q, sh_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rda_q, rda_d;
    logic       fe_q, fe_d;
    logic       ov_q, ov_d;
    logic       complete_s;

    assign rxs_s = sync_q[1];

    // Two-flop synchroniser for the asynchronous serial input (idles high).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd_i};
        end
    end

    // State, counters, shift register and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            tcnt_q    <= TCNT_ZERO;
            bcnt_q    <= 3'd0;
            sh_q      <= 8'h00;
            rx_data_q <= 8'h00;
            rda_q     <= 1'b0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            bcnt_q    <= bcnt_d;
            sh_q      <= sh_d;
            rx_data_q <= rx_data_d;
            rda_q     <= rda_d;
            fe_q      <= fe_d;
            ov_q      <= ov_d;
        end
    end

    // Receive FSM: next state, counters and shift register.
    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        bcnt_d     = bcnt_q;
        sh_d       = sh_q;
        complete_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable_i && (rxs_s == 1'b0)) begin
                    state_d = S_START;
                    tcnt_d  = TCNT_ZERO;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (enable_i) begin
                    if (tcnt_q == HALF_M1) begin
                        tcnt_d = TCNT_ZERO;
                        bcnt_d = 3'd0;
                        // A line that is high again at mid-start was a glitch.
                        if (rxs_s == 1'b0) begin
                            state_d = S_DATA;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TCNT_ONE;
                    end
                end else begin
                    tcnt_d = tcnt_q;
                end
            end
            S_DATA: begin
                if (enable_i) begin
                    if (tcnt_q == FULL_M1) begin
                        sh_d   = {rxs_s, sh_q[7:1]};
                        tcnt_d = TCNT_ZERO;
                        if (bcnt_q == 3'd7) begin
                            state_d = S_STOP;
                        end else begin
                            bcnt_d = bcnt_q + 3'd1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TCNT_ONE;
                    end
                end else begin
                    tcnt_d = tcnt_q;
                end
            end
            S_STOP: begin
                if (enable_i) begin
                    if (tcnt_q == FULL_M1) begin
                        complete_s = 1'b1;
                        tcnt_d     = TCNT_ZERO;
                        state_d    = S_IDLE;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_ONE;
                    end
                end else begin
                    tcnt_d = tcnt_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                tcnt_d  = TCNT_ZERO;
                bcnt_d  = 3'd0;
            end
        endcase
    end

    // Output status: completion beats a simultaneous clear, and a clear in
    // the same cycle means the old byte was consumed, so no overrun.
    always_comb begin
        rx_data_d = rx_data_q;
        rda_d     = rda_q;
        fe_d      = fe_q;
        ov_d      = ov_q;
        if (complete_s) begin
            rx_data_d = sh_q;
            rda_d     = 1'b1;
            fe_d      = ~rxs_s;
            ov_d      = rda_q & ~clr_rda_i;
        end else if (clr_rda_i) begin
            rda_d = 1'b0;
            fe_d  = 1'b0;
            ov_d  = 1'b0;
        end else begin
            rda_d = rda_q;
        end
    end

    assign rx_data_o   = rx_data_q;
    assign rda_o       = rda_q;
    assign frame_err_o = fe_q;
    assign overrun_o   = ov_q;

endmodule
